// File: rtl/car_game_pkg.sv
// Shared constants and types for the two-car dodging game.
package car_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // Screen geometry (VGA 640x480)
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Default lane centres: lanes 0/1 belong to car1, lanes 2/3 to car2
    localparam int LANE0_X_DEF = 80;
    localparam int LANE1_X_DEF = 240;
    localparam int LANE2_X_DEF = 400;
    localparam int LANE3_X_DEF = 560;

    // Car and object sizes, shared with the collision detector
    localparam int CAR_W    = 40;
    localparam int CAR_H    = 60;
    localparam int CAR_Y    = 400;
    localparam int OBJ_SIZE = 30;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Pick one of two lane centres from a random bit
    function automatic logic [9:0] pick_lane(input logic sel, input int lane_a, input int lane_b);
        return sel ? 10'(lane_b) : 10'(lane_a);
    endfunction

endpackage

// File: rtl/object_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; free-running from reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    // Shift left, feedback from taps 16,14,13,11 into bit 0
    always_ff @(posedge clk) begin
        if (rst) value <= SEED;
        else     value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
    end

endmodule

// File: rtl/object_spawner.sv
// Falling-object generator: spawns one object per car, moves them down on
// a tick, keeps score from collect edges and stops on end_game.
module object_spawner
    import car_game_pkg::*;
#(
    parameter int          TICK_DIV        = 1_000_000,
    parameter int          Y_START         = 0,
    parameter int          Y_MAX           = 479,
    parameter int          LANE0_X         = LANE0_X_DEF,
    parameter int          LANE1_X         = LANE1_X_DEF,
    parameter int          LANE2_X         = LANE2_X_DEF,
    parameter int          LANE3_X         = LANE3_X_DEF,
    parameter int          WAVES_PER_LEVEL = 8,
    parameter int          STEP_MAX        = 4,
    parameter logic [15:0] SEED            = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        score,
    input  logic        end_game,
    output logic [9:0]  object_x,
    output logic [9:0]  object_x2,
    output logic [8:0]  object_y,
    output logic        object_is_square,
    output logic        object_is_square2,
    output logic        object_active,
    output logic        game_over,
    output logic [15:0] score_count,
    output logic [2:0]  level
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [7:0]    wave_count;
    logic          score_r, score_d;
    logic [15:0]   lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr)
    );

    // Only the low four LFSR bits pick a wave; upper bits just feed the shift
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[15:4];

    logic [9:0] wave_x, wave_x2;
    logic [9:0] y_sum;
    logic [7:0] wave_inc;
    logic       lvl_up, score_edge;

    assign wave_x     = pick_lane(lfsr[0], LANE0_X, LANE1_X);
    assign wave_x2    = pick_lane(lfsr[1], LANE2_X, LANE3_X);
    assign y_sum      = {1'b0, object_y} + {7'd0, level};
    assign wave_inc   = wave_count + 8'd1;
    assign lvl_up     = ((32'(wave_inc) % WAVES_PER_LEVEL) == 0) && (level < 3'(STEP_MAX));
    assign score_edge = score_r & ~score_d;

    // Game FSM with object position, wave content, score and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            tick_cnt          <= '0;
            wave_count        <= '0;
            score_r           <= 1'b0;
            score_d           <= 1'b0;
            object_x          <= 10'(LANE0_X);
            object_x2         <= 10'(LANE2_X);
            object_y          <= 9'(Y_START);
            object_is_square  <= 1'b0;
            object_is_square2 <= 1'b0;
            object_active     <= 1'b0;
            game_over         <= 1'b0;
            score_count       <= '0;
            level             <= 3'd1;
        end else begin
            score_r <= score;
            score_d <= score_r;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        state             <= ST_FALL;
                        object_active     <= 1'b1;
                        game_over         <= 1'b0;
                        object_x          <= wave_x;
                        object_x2         <= wave_x2;
                        object_is_square  <= lfsr[2];
                        object_is_square2 <= lfsr[3];
                        object_y          <= 9'(Y_START);
                        score_count       <= '0;
                        wave_count        <= '0;
                        tick_cnt          <= '0;
                        level             <= 3'd1;
                    end
                end
                ST_FALL: begin
                    // end_game wins over any score edge or tick in the same cycle
                    if (end_game) begin
                        state     <= ST_OVER;
                        game_over <= 1'b1;
                    end else begin
                        if (score_edge && score_count != 16'hFFFF)
                            score_count <= score_count + 16'd1;
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (y_sum > 10'(Y_MAX)) begin
                                // Respawn replaces the move: new wave at the top
                                object_y          <= 9'(Y_START);
                                object_x          <= wave_x;
                                object_x2         <= wave_x2;
                                object_is_square  <= lfsr[2];
                                object_is_square2 <= lfsr[3];
                                wave_count        <= wave_inc;
                                if (lvl_up) level <= level + 3'd1;
                            end else begin
                                object_y <= y_sum[8:0];
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_object_spawner.sv
// Randomized scoreboard bench for object_spawner with a behavioural game model.
module tb_object_spawner;

    localparam int          TD   = 3;
    localparam int          WPL  = 8;
    localparam int          SMAX = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, score = 1'b0, end_game = 1'b0;
    logic [9:0]  object_x, object_x2;
    logic [8:0]  object_y;
    logic        object_is_square, object_is_square2, object_active, game_over;
    logic [15:0] score_count;
    logic [2:0]  level;

    object_spawner #(
        .TICK_DIV(TD), .Y_START(0), .Y_MAX(479),
        .LANE0_X(80), .LANE1_X(240), .LANE2_X(400), .LANE3_X(560),
        .WAVES_PER_LEVEL(WPL), .STEP_MAX(SMAX), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .score(score), .end_game(end_game),
        .object_x(object_x), .object_x2(object_x2), .object_y(object_y),
        .object_is_square(object_is_square), .object_is_square2(object_is_square2),
        .object_active(object_active), .game_over(game_over),
        .score_count(score_count), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  x2;
        logic [8:0]  y;
        logic        sq;
        logic        sq2;
        logic        act;
        logic        go;
        logic [15:0] sc;
        logic [2:0]  lvl;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   done   = 1'b0;

    // Behavioural model: game described by "playing"/"finished" flags,
    // elapsed fall cycles and a score-input history
    bit          m_valid = 1'b0;
    bit          m_play, m_done, m_xr, m_x2r, m_sq, m_sq2, m_s1, m_s2;
    int          m_y, m_lvl, m_waves, m_elapsed, m_sc;
    logic [15:0] m_lfsr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, want);
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.x   = m_xr  ? 10'd240 : 10'd80;
        o.x2  = m_x2r ? 10'd560 : 10'd400;
        o.y   = 9'(m_y);
        o.sq  = m_sq;
        o.sq2 = m_sq2;
        o.act = m_play | m_done;
        o.go  = m_done;
        o.sc  = 16'(m_sc);
        o.lvl = 3'(m_lvl);
        return o;
    endfunction

    task automatic load_wave();
        m_xr = m_lfsr[0]; m_x2r = m_lfsr[1]; m_sq = m_lfsr[2]; m_sq2 = m_lfsr[3];
    endtask

    task automatic model_step(input bit r, input bit st, input bit sc, input bit eg);
        bit edge_seen;
        if (r) begin
            m_play = 0; m_done = 0; m_xr = 0; m_x2r = 0; m_sq = 0; m_sq2 = 0;
            m_y = 0; m_lvl = 1; m_waves = 0; m_elapsed = 0; m_sc = 0;
            m_s1 = 0; m_s2 = 0; m_lfsr = SEED;
        end else begin
            edge_seen = m_s1 && !m_s2;
            if (!m_play) begin
                if (st) begin
                    m_play = 1; m_done = 0; load_wave();
                    m_y = 0; m_sc = 0; m_waves = 0; m_elapsed = 0; m_lvl = 1;
                end
            end else if (eg) begin
                m_play = 0; m_done = 1;
            end else begin
                if (edge_seen && m_sc < 65535) m_sc++;
                m_elapsed++;
                if (m_elapsed % TD == 0) begin
                    if (m_y + m_lvl > 479) begin
                        m_y = 0; load_wave(); m_waves++;
                        if ((m_waves % WPL) == 0 && m_lvl < SMAX) m_lvl++;
                    end else begin
                        m_y += m_lvl;
                    end
                end
            end
            m_s2 = m_s1; m_s1 = sc;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    // One clock of stimulus: queue expectation for the state just clocked in,
    // then drive this cycle's inputs and advance the model
    task automatic cyc(input bit r, input bit st, input bit sc, input bit eg);
        @(posedge clk); #1;
        if (m_valid) exp_q.push_back(model_obs());
        rst = r; start = st; score = sc; end_game = eg;
        model_step(r, st, sc, eg);
        m_valid = 1;
    endtask

    task automatic run_to_waves(input int n);
        int guard = 0;
        while (m_waves < n && guard < 40000) begin
            cyc(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0), 0);
            guard++;
        end
        if (m_waves < n) chk("wave_timeout", 32'(m_waves), 32'(n));
    endtask

    // Monitor: every cycle the DUT presents a state, compare to the model
    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{object_x, object_x2, object_y, object_is_square, object_is_square2,
                  object_active, game_over, score_count, level};
            checks++;
            if (a === e) passes++;
            else $display("FAIL state: got x=%0d x2=%0d y=%0d sq=%b sq2=%b act=%b go=%b sc=%0d lvl=%0d expected x=%0d x2=%0d y=%0d sq=%b sq2=%b act=%b go=%b sc=%0d lvl=%0d",
                          a.x, a.x2, a.y, a.sq, a.sq2, a.act, a.go, a.sc, a.lvl,
                          e.x, e.x2, e.y, e.sq, e.sq2, e.act, e.go, e.sc, e.lvl);
        end
    end

    initial begin
        int guard;
        // Reset, then idle with noise on score/end_game
        repeat (3) cyc(1, 0, 0, 0);
        repeat (200) cyc(0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
        chk("idle_y", 32'(object_y), 0);
        chk("idle_active", 32'(object_active), 0);
        chk("idle_level", 32'(level), 1);

        // Start and watch the fall cadence
        cyc(0, 1, 0, 0);
        repeat (TD) cyc(0, 0, 0, 0);
        chk("fall_y0", 32'(object_y), 0);
        chk("fall_active", 32'(object_active), 1);
        cyc(0, 0, 0, 0);
        chk("fall_y1", 32'(object_y), 1);
        repeat (TD) cyc(0, 0, 0, 0);
        chk("fall_y2", 32'(object_y), 2);

        // Held score counts once, then a one-cycle pulse
        repeat (5) cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0);
        chk("score_two", 32'(score_count), 2);

        // end_game together with a score rise at y=200
        guard = 0;
        while (m_y != 200 && guard < 5000) begin cyc(0, 0, 0, 0); guard++; end
        chk("reach_y200", 32'(m_y), 200);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("over_flag", 32'(game_over), 1);
        chk("over_y", 32'(object_y), 200);
        chk("over_score", 32'(score_count), 2);
        repeat (4) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (TD + 2) cyc(0, 0, 0, 0);
        chk("frozen_y", 32'(object_y), 200);
        chk("frozen_score", 32'(score_count), 2);

        // Restart from OVER
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("restart_y", 32'(object_y), 0);
        chk("restart_score", 32'(score_count), 0);
        chk("restart_level", 32'(level), 1);
        chk("restart_over", 32'(game_over), 0);

        // Level ramp across many respawns
        run_to_waves(8);
        cyc(0, 0, 0, 0);
        chk("level_w8", 32'(level), 2);
        run_to_waves(24);
        cyc(0, 0, 0, 0);
        chk("level_w24", 32'(level), 4);
        run_to_waves(40);
        cyc(0, 0, 0, 0);
        chk("level_w40", 32'(level), 4);

        // Reset in the middle of a game
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_active", 32'(object_active), 0);
        chk("rst_score", 32'(score_count), 0);
        chk("rst_level", 32'(level), 1);

        // Fully random traffic
        for (int i = 0; i < 3000; i++)
            cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));

        cyc(0, 0, 0, 0);
        @(negedge clk); @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        done = 1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
